// File: rtl/endeavour_sd_uart_bridge.sv
// UART-to-SD command bridge: 6 received UART bytes go out as one 48-bit SD command, and the card response (or 0xFF on timeout) comes back over UART.
// Define SD_CRC7_EN to replace the last command byte with {CRC7 of bytes 0..4, 1'b1}.
module endeavour_sd_uart_bridge #(
    parameter int CLK_FREQ         = 100_000_000,
    parameter int UART_BAUD        = 115_200,
    parameter int OVERRIDE_DIVISOR = 0,
    parameter int RESET_DELAY      = 1_000_000,
    parameter int SD_CLK_DIV       = 124,
    parameter int NCR_MAX          = 64
) (
    input  logic       io_clk100mhz,
    input  logic       io_nreset,
    input  logic       io_uart_rx,
    output logic       io_uart_tx,
    output logic       io_sdcard_clk,
    inout  wire        io_sdcard_cmd,
    inout  wire  [3:0] io_sdcard_data
);
    localparam int DIV = (OVERRIDE_DIVISOR != 0) ? OVERRIDE_DIVISOR : CLK_FREQ / UART_BAUD - 1;
    localparam int UW  = $clog2(DIV + 2);
    localparam int RW  = $clog2(RESET_DELAY + 2);
    localparam int SW  = $clog2(SD_CLK_DIV + 2);
    localparam int NW  = $clog2(NCR_MAX + 1);
    localparam logic [UW-1:0] U_FULL = UW'(DIV);
    localparam logic [UW-1:0] U_HALF = UW'(DIV / 2);
    localparam logic [RW-1:0] R_LAST = RW'((RESET_DELAY > 0) ? RESET_DELAY - 1 : 0);
    localparam logic [SW-1:0] S_FULL = SW'(SD_CLK_DIV);
    localparam logic [NW-1:0] N_LAST = NW'(NCR_MAX - 1);

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_REPLY, S_TIMEOUT} state_t;

    // Reset stretcher: asserts asynchronously, releases RESET_DELAY clocks after io_nreset.
    logic [RW-1:0] rst_cnt_q;
    logic          rst_n_q;
    always_ff @(posedge io_clk100mhz or negedge io_nreset) begin
        if (!io_nreset) begin
            rst_cnt_q <= '0;
            rst_n_q   <= 1'b0;
        end else if (!rst_n_q) begin
            if (rst_cnt_q >= R_LAST) rst_n_q <= 1'b1;
            else                     rst_cnt_q <= rst_cnt_q + 1'b1;
        end
    end

    state_t        state_q, state_d;
    logic [47:0]   cmd_sr_q, cmd_sr_d, resp_q, resp_d;
    logic [5:0]    bit_q, bit_d;
    logic [NW-1:0] ncr_q, ncr_d;
    logic [2:0]    left_q, left_d;
    logic [3:0]    extra_q, extra_d;
    logic          tx_start, tx_ready;
    logic [7:0]    tx_data;

    // UART receiver; rx_bit_q: 0 idle, 1 start, 2..9 data, 10 stop.
    logic [1:0]    rx_sync_q;
    logic          rx_prev_q, rx_valid_q, rx_ferr_q;
    logic [3:0]    rx_bit_q;
    logic [UW-1:0] rx_cnt_q;
    logic [7:0]    rx_sr_q;
    logic          rx_s;
    assign rx_s = rx_sync_q[1];

    always_ff @(posedge io_clk100mhz or negedge rst_n_q) begin
        if (!rst_n_q) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_bit_q   <= '0;
            rx_cnt_q   <= '0;
            rx_sr_q    <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], io_uart_rx};
            rx_prev_q  <= rx_s;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            if (rx_bit_q == 4'd0) begin
                if (rx_prev_q && !rx_s) begin
                    rx_bit_q <= 4'd1;
                    rx_cnt_q <= '0;
                end
            end else if (rx_bit_q == 4'd1) begin
                if (rx_cnt_q == U_HALF) begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= rx_s ? 4'd0 : 4'd2;
                end else begin
                    rx_cnt_q <= rx_cnt_q + 1'b1;
                end
            end else if (rx_cnt_q != U_FULL) begin
                rx_cnt_q <= rx_cnt_q + 1'b1;
            end else begin
                rx_cnt_q <= '0;
                if (rx_bit_q == 4'd10) begin
                    rx_bit_q   <= 4'd0;
                    rx_valid_q <= rx_s;
                    rx_ferr_q  <= !rx_s;
                end else begin
                    rx_sr_q  <= {rx_s, rx_sr_q[7:1]};
                    rx_bit_q <= rx_bit_q + 1'b1;
                end
            end
        end
    end

    // Frame assembly; a byte arriving while a command is in flight is dropped.
    logic [7:0] buf_q [6];
    logic [2:0] idx_q;
    logic       go_q, busy;
    assign busy = (state_q != S_IDLE) || (extra_q != 4'd0) || go_q;

    always_ff @(posedge io_clk100mhz) begin
        if (rx_valid_q && !busy) buf_q[idx_q] <= rx_sr_q;
    end

    always_ff @(posedge io_clk100mhz or negedge rst_n_q) begin
        if (!rst_n_q) begin
            idx_q <= '0;
            go_q  <= 1'b0;
        end else begin
            go_q <= 1'b0;
            if (rx_ferr_q) begin
                idx_q <= '0;
            end else if (rx_valid_q && !busy) begin
                if (idx_q == 3'd5) begin
                    idx_q <= '0;
                    go_q  <= 1'b1;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    // SD clock: runs only while a command is active or trailing clocks remain.
    logic [SW-1:0] sd_cnt_q;
    logic          sd_clk_q, sd_en, sd_tick, sd_rise, sd_fall;
    assign sd_en   = (state_q == S_SEND) || (state_q == S_WAIT) || (state_q == S_RECV) || (extra_q != 4'd0);
    assign sd_tick = sd_en && (sd_cnt_q == S_FULL);
    assign sd_rise = sd_tick && !sd_clk_q;
    assign sd_fall = sd_tick && sd_clk_q;

    always_ff @(posedge io_clk100mhz or negedge rst_n_q) begin
        if (!rst_n_q) begin
            sd_cnt_q <= '0;
            sd_clk_q <= 1'b0;
        end else if (!sd_en) begin
            sd_cnt_q <= '0;
            sd_clk_q <= 1'b0;
        end else if (sd_tick) begin
            sd_cnt_q <= '0;
            sd_clk_q <= !sd_clk_q;
        end else begin
            sd_cnt_q <= sd_cnt_q + 1'b1;
        end
    end

    // UART transmitter; tx_ready also covers the final stop-bit clock so bytes chain gaplessly.
    logic [9:0]    tx_sr_q;
    logic [3:0]    tx_left_q;
    logic [UW-1:0] tx_cnt_q;
    assign tx_ready = (tx_left_q == 4'd0) || ((tx_left_q == 4'd1) && (tx_cnt_q == U_FULL));

    always_ff @(posedge io_clk100mhz or negedge rst_n_q) begin
        if (!rst_n_q) begin
            tx_sr_q   <= '1;
            tx_left_q <= '0;
            tx_cnt_q  <= '0;
        end else if (tx_start) begin
            tx_sr_q   <= {1'b1, tx_data, 1'b0};
            tx_left_q <= 4'd10;
            tx_cnt_q  <= '0;
        end else if (tx_left_q != 4'd0) begin
            if (tx_cnt_q == U_FULL) begin
                tx_cnt_q  <= '0;
                tx_sr_q   <= {1'b1, tx_sr_q[9:1]};
                tx_left_q <= tx_left_q - 1'b1;
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end
    end

`ifdef SD_CRC7_EN
    logic [6:0] crc_q, crc_d, crc_nx;
    logic       crc_fb;
    assign crc_fb = crc_q[6] ^ cmd_sr_q[47];
    assign crc_nx = {crc_q[5:0], 1'b0} ^ {3'b000, crc_fb, 2'b00, crc_fb};
`endif

    always_ff @(posedge io_clk100mhz or negedge rst_n_q) begin
        if (!rst_n_q) begin
            state_q  <= S_IDLE;
            cmd_sr_q <= '0;
            resp_q   <= '0;
            bit_q    <= '0;
            ncr_q    <= '0;
            left_q   <= '0;
            extra_q  <= '0;
`ifdef SD_CRC7_EN
            crc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cmd_sr_q <= cmd_sr_d;
            resp_q   <= resp_d;
            bit_q    <= bit_d;
            ncr_q    <= ncr_d;
            left_q   <= left_d;
            extra_q  <= extra_d;
`ifdef SD_CRC7_EN
            crc_q    <= crc_d;
`endif
        end
    end

    assign tx_data = resp_q[47:40];

    always_comb begin
        state_d  = state_q;
        cmd_sr_d = cmd_sr_q;
        resp_d   = resp_q;
        bit_d    = bit_q;
        ncr_d    = ncr_q;
        left_d   = left_q;
        extra_d  = extra_q;
        tx_start = 1'b0;
`ifdef SD_CRC7_EN
        crc_d    = crc_q;
`endif
        if (sd_fall && (extra_q != 4'd0)) extra_d = extra_q - 1'b1;
        unique case (state_q)
            S_IDLE: if (go_q) begin
                state_d  = S_SEND;
                cmd_sr_d = {buf_q[0], buf_q[1], buf_q[2], buf_q[3], buf_q[4], buf_q[5]};
                bit_d    = '0;
`ifdef SD_CRC7_EN
                crc_d    = '0;
`endif
            end
            S_SEND: if (sd_fall) begin
                if (bit_q == 6'd47) begin
                    state_d = S_WAIT;
                    ncr_d   = '0;
                end else begin
                    bit_d    = bit_q + 1'b1;
                    cmd_sr_d = {cmd_sr_q[46:0], 1'b0};
`ifdef SD_CRC7_EN
                    if (bit_q < 6'd40)  crc_d = crc_nx;
                    if (bit_q == 6'd39) cmd_sr_d[47:40] = {crc_nx, 1'b1};
`endif
                end
            end
            // The card changes CMD on falling edges, so the line is stable at a rise event.
            S_WAIT: if (sd_rise) begin
                if (!io_sdcard_cmd) begin
                    state_d = S_RECV;
                    resp_d  = '0;
                    bit_d   = 6'd1;
                end else if (ncr_q == N_LAST) begin
                    state_d = S_TIMEOUT;
                    resp_d  = '1;
                    left_d  = 3'd1;
                    extra_d = 4'd9;
                end else begin
                    ncr_d = ncr_q + 1'b1;
                end
            end
            S_RECV: if (sd_rise) begin
                resp_d = {resp_q[46:0], io_sdcard_cmd};
                if (bit_q == 6'd47) begin
                    state_d = S_REPLY;
                    left_d  = 3'd6;
                    extra_d = 4'd9;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            S_REPLY, S_TIMEOUT: begin
                if (left_q != 3'd0) begin
                    if (tx_ready) begin
                        tx_start = 1'b1;
                        resp_d   = {resp_q[39:0], 8'h00};
                        left_d   = left_q - 1'b1;
                    end
                end else if (tx_left_q == 4'd0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign io_uart_tx     = tx_sr_q[0];
    assign io_sdcard_clk  = sd_clk_q;
    assign io_sdcard_cmd  = (state_q == S_SEND) ? cmd_sr_q[47] : 1'bz;
    assign io_sdcard_data = 4'bzzzz;

endmodule

// File: tb/tb_endeavour_sd_uart_bridge.sv
// Bench for endeavour_sd_uart_bridge: UART host driver, SD card model, command/reply scoreboards.
module tb_endeavour_sd_uart_bridge;
    localparam int BIT = 6;

    logic       clk = 1'b0;
    logic       nreset;
    logic       uart_rx;
    logic       uart_tx;
    logic       sdclk;
    wire        sd_cmd;
    wire  [3:0] sd_data;
    logic       card_oe = 1'b0;
    logic       card_bit = 1'b1;

    always #5 clk = ~clk;

    pullup (sd_cmd);
    pullup (sd_data[0]);
    pullup (sd_data[1]);
    pullup (sd_data[2]);
    pullup (sd_data[3]);
    assign sd_cmd = card_oe ? card_bit : 1'bz;

    endeavour_sd_uart_bridge #(
        .CLK_FREQ(100_000_000), .UART_BAUD(115_200), .OVERRIDE_DIVISOR(5),
        .RESET_DELAY(3), .SD_CLK_DIV(3), .NCR_MAX(64)
    ) dut (
        .io_clk100mhz(clk), .io_nreset(nreset), .io_uart_rx(uart_rx), .io_uart_tx(uart_tx),
        .io_sdcard_clk(sdclk), .io_sdcard_cmd(sd_cmd), .io_sdcard_data(sd_data)
    );

    typedef struct {
        logic [47:0] frame;
        logic [47:0] wire_cmd;
        bit          resp;
        logic [47:0] card;
        int          rises;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int sessions = 0;
    int exp_sessions = 0;
    bit in_sess = 1'b0;

    logic [47:0] cmd_q[$];
    logic [47:0] card_q[$];
    bit          card_en_q[$];
    int          rises_q[$];
    logic [7:0]  uart_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = stop;
        repeat (BIT) @(negedge clk);
        uart_rx = 1'b1;
        if (!stop) repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 0; i < 6; i++) send_byte(f[47-8*i -: 8], 1'b1);
    endtask

    task automatic issue(input vec_t v);
        cmd_q.push_back(v.wire_cmd);
        card_en_q.push_back(v.resp);
        card_q.push_back(v.card);
        rises_q.push_back(v.rises);
        exp_sessions++;
        if (v.resp) for (int i = 0; i < 6; i++) uart_q.push_back(v.card[47-8*i -: 8]);
        else        uart_q.push_back(8'hFF);
        send_frame(v.frame);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (n < 20000 && (cmd_q.size() != 0 || uart_q.size() != 0 || rises_q.size() != 0 || in_sess)) begin
            @(negedge clk);
            n++;
        end
        check({name, "_completes"}, 64'(n < 20000), 64'd1);
        repeat (20) @(negedge clk);
    endtask

    // SD monitor and card model: commands are captured on the first 48 rises of a clock burst.
    initial begin
        logic        prev;
        int          low_run, sess_rises, sess_bits, card_falls;
        bit          card_arm;
        logic [47:0] cap, card_data;
        prev = 1'b0; low_run = 1000; sess_rises = 0; sess_bits = 0;
        card_falls = 0; card_arm = 1'b0; cap = '0; card_data = '0;
        forever begin
            @(negedge clk);
            if (sdclk && !prev) begin
                if (!in_sess) begin
                    in_sess = 1'b1;
                    sess_rises = 0;
                    sess_bits = 0;
                    sessions++;
                end
                sess_rises++;
                if (sess_bits < 48) begin
                    cap = {cap[46:0], sd_cmd};
                    sess_bits++;
                    if (sess_bits == 48) begin
                        if (cmd_q.size() == 0) begin
                            n_vec++; n_err++;
                            $display("FAIL sd_cmd: got unexpected command %h required none", cap);
                        end else begin
                            check("sd_cmd", 64'(cap), 64'(cmd_q.pop_front()));
                            card_arm = card_en_q.pop_front();
                            card_data = card_q.pop_front();
                            card_falls = 0;
                        end
                    end
                end
            end
            if (!sdclk && prev && card_arm) begin
                card_falls++;
                if (card_falls >= 10 && card_falls < 58) begin
                    card_oe = 1'b1;
                    card_bit = card_data[57-card_falls];
                end else if (card_falls == 58) begin
                    card_oe = 1'b0;
                    card_arm = 1'b0;
                end
            end
            if (!sdclk) low_run++;
            else        low_run = 0;
            if (in_sess && low_run == 40) begin
                in_sess = 1'b0;
                if (rises_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL sd_rises: got unexpected burst of %0d rises required none", sess_rises);
                end else begin
                    check("sd_rises", 64'(sess_rises), 64'(rises_q.pop_front()));
                end
            end
            prev = sdclk;
        end
    end

    // UART reply monitor: samples mid-bit and checks stop bit together with the data.
    initial begin
        logic       p, stop;
        logic [7:0] b;
        p = 1'b1; b = '0; stop = 1'b0;
        forever begin
            @(negedge clk);
            if (p && !uart_tx && nreset) begin
                repeat (BIT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (BIT) @(negedge clk);
                stop = uart_tx;
                if (uart_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL uart_byte: got unexpected %h required none", b);
                end else begin
                    check("uart_byte", {55'd0, stop, b}, {55'd0, 1'b1, uart_q.pop_front()});
                end
            end
            p = uart_tx;
        end
    end

    initial begin
        vec_t vecs[4];
        vec_t v;
        int   s0;
        vecs[0] = '{48'h400000000095, 48'h400000000095, 1'b0, 48'h0, 120};
        vecs[1] = '{48'h48000001AA87, 48'h48000001AA87, 1'b1, 48'h08000001AA13, 113};
        vecs[2] = '{48'h770000000065, 48'h770000000065, 1'b1, 48'h370000012083, 113};
        vecs[3] = '{48'h510000000055, 48'h510000000055, 1'b1, 48'h110000090067, 113};

        nreset = 1'b0;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_uart_tx", 64'(uart_tx), 64'd1);
        check("rst_sdclk", 64'(sdclk), 64'd0);
        check("rst_cmd_released", 64'(sd_cmd), 64'd1);
        check("rst_data_released", 64'(sd_data), 64'hF);
        nreset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_uart_tx", 64'(uart_tx), 64'd1);
            check("rst_hold_sdclk", 64'(sdclk), 64'd0);
        end
        repeat (10) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            issue(vecs[i]);
            wait_done("vector");
        end

        // Framing error in the 4th byte discards the partial frame.
        s0 = sessions;
        send_byte(8'h40, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        issue(vecs[0]);
        wait_done("framing");
        check("framing_one_cmd", 64'(sessions - s0), 64'd1);

        // Bytes arriving during WAIT are ignored; the following frame runs normally.
        s0 = sessions;
        issue(vecs[0]);
        begin
            int n;
            n = 0;
            while (n < 5000 && cmd_q.size() != 0) begin
                @(negedge clk);
                n++;
            end
            check("busy_cmd_seen", 64'(n < 5000), 64'd1);
        end
        send_frame(48'h48000001AA87);
        wait_done("busy");
        issue(vecs[1]);
        wait_done("after_busy");
        check("busy_two_cmds", 64'(sessions - s0), 64'd2);

`ifdef SD_CRC7_EN
        v = '{48'h400000000000, 48'h400000000095, 1'b0, 48'h0, 120};
        issue(v);
        wait_done("crc_cmd0");
        v = '{48'h48000001AA00, 48'h48000001AA87, 1'b0, 48'h0, 120};
        issue(v);
        wait_done("crc_cmd8");
`else
        v = vecs[0];
`endif

        repeat (200) @(negedge clk);
        check("idle_sdclk", 64'(sdclk), 64'd0);
        check("idle_uart_tx", 64'(uart_tx), 64'd1);
        check("total_cmds", 64'(sessions), 64'(exp_sessions));
        check("last_frame_cmd", 64'(v.wire_cmd[47:40]), 64'(cmd_q.size() == 0 ? 8'h40 : 8'h00));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
